// File: rtl/aes_uart_pkg.sv
// rtl/aes_uart_pkg.sv - shared types and constants for the AES-to-UART top level
`timescale 1ns/1ps
package aes_uart_pkg;

    typedef enum logic [1:0] {WAIT_AES, SEND, DONE} seq_state_e;

    typedef enum logic [1:0] {TX_IDLE, TX_START_BIT, TX_DATA_BITS, TX_STOP_BIT} uart_state_e;

    localparam logic [127:0] DEFAULT_PLAIN = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] DEFAULT_KEY   = 128'h000102030405060708090a0b0c0d0e0f;

    localparam int   NUM_BYTES = 16;
    localparam logic START     = 1'b0;
    localparam logic STOP      = 1'b1;
    localparam int   DATA_BITS = 8;

    // Byte idx of a big-endian 128-bit word; byte 0 is bits [127:120].
    function automatic logic [7:0] cipher_byte(input logic [127:0] c, input logic [3:0] idx);
        logic [7:0] b;
        b = '0;
        for (int k = 0; k < NUM_BYTES; k++) begin
            if (idx == 4'(k)) begin
                b = c[127-8*k -: 8];
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/aes_top.sv
// rtl/aes_top.sv - AES-128 encryption core with a registered ciphertext output
`timescale 1ns/1ps
module aes_top (
    input  logic         i_clock,
    input  logic [127:0] i_plain,
    input  logic [127:0] i_key,
    output logic [127:0] o_cipher
);

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = '0;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xtime(x);
            y = y >> 1;
        end
        return p;
    endfunction

    // S-box computed as GF(2^8) inverse (a^254) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq, inv;
        sq  = a;
        inv = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // State byte r+4c lives at bits [127-8*(r+4c) -: 8] (column-major).
    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                o[127-8*(r+4*c) -: 8] = sbox(s[127-8*(r+4*((c+r)%4)) -: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                 a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                 a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                 xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
        return o;
    endfunction

    function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rcon);
        logic [31:0] t, w0, w1, w2, w3;
        t  = {sbox(k[23:16]) ^ rcon, sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])};
        w0 = k[127:96] ^ t;
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] encrypt(input logic [127:0] p, input logic [127:0] k);
        logic [127:0] st, rk;
        logic [7:0]   rcon;
        st   = p ^ k;
        rk   = k;
        rcon = 8'h01;
        for (int rnd = 1; rnd <= 10; rnd++) begin
            rk   = next_key(rk, rcon);
            rcon = xtime(rcon);
            st   = sub_shift(st);
            if (rnd < 10) st = mix(st);
            st = st ^ rk;
        end
        return st;
    endfunction

    // Register the fully unrolled result; latency is one clock.
    always_ff @(posedge i_clock) begin
        o_cipher <= encrypt(i_plain, i_key);
    end

endmodule

// File: rtl/uart_tx_8n1.sv
// rtl/uart_tx_8n1.sv - 8N1 UART transmitter with registered serial output
`timescale 1ns/1ps
module uart_tx_8n1
    import aes_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       tx_serial
);

    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT + 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    uart_state_e       state_q, state_d;
    logic [BAUD_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shreg_q, shreg_d;
    logic              tx_serial_q, tx_serial_d;
    logic              bit_end;

    assign bit_end   = (baud_cnt_q == BAUD_LAST);
    assign tx_busy   = (state_q != TX_IDLE);
    assign tx_serial = tx_serial_q;

    // Frame sequencing; the serial level is registered so it changes with the state.
    always_comb begin
        state_d     = state_q;
        baud_cnt_d  = bit_end ? '0 : baud_cnt_q + 1'b1;
        bit_idx_d   = bit_idx_q;
        shreg_d     = shreg_q;
        tx_serial_d = tx_serial_q;
        case (state_q)
            TX_IDLE: begin
                baud_cnt_d  = '0;
                tx_serial_d = STOP;
                if (tx_start) begin
                    state_d     = TX_START_BIT;
                    shreg_d     = tx_data;
                    bit_idx_d   = '0;
                    tx_serial_d = START;
                end
            end
            TX_START_BIT: begin
                if (bit_end) begin
                    state_d     = TX_DATA_BITS;
                    tx_serial_d = shreg_q[0];
                end
            end
            TX_DATA_BITS: begin
                if (bit_end) begin
                    if (bit_idx_q == 3'(DATA_BITS - 1)) begin
                        state_d     = TX_STOP_BIT;
                        tx_serial_d = STOP;
                    end else begin
                        bit_idx_d   = bit_idx_q + 1'b1;
                        shreg_d     = shreg_q >> 1;
                        tx_serial_d = shreg_q[1];
                    end
                end
            end
            TX_STOP_BIT: begin
                if (bit_end) state_d = TX_IDLE;
            end
            default: state_d = TX_IDLE;
        endcase
    end

    // State register; the line goes idle-high the moment rst rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= TX_IDLE;
            baud_cnt_q  <= '0;
            bit_idx_q   <= '0;
            shreg_q     <= '0;
            tx_serial_q <= STOP;
        end else begin
            state_q     <= state_d;
            baud_cnt_q  <= baud_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shreg_q     <= shreg_d;
            tx_serial_q <= tx_serial_d;
        end
    end

endmodule

// File: rtl/aes_uart_fpga_top.sv
// rtl/aes_uart_fpga_top.sv - encrypt one fixed block and send the ciphertext once over UART
`timescale 1ns/1ps
module aes_uart_fpga_top
    import aes_uart_pkg::*;
#(
    parameter int           CLKS_PER_BIT = 87,
    parameter int           AES_WAIT     = 32,
    parameter logic [127:0] PLAIN        = DEFAULT_PLAIN,
    parameter logic [127:0] KEY          = DEFAULT_KEY
) (
    input  logic clk,
    input  logic rst,
    output logic uart_tx
);

    localparam int WAIT_W = $clog2(AES_WAIT + 1);

    seq_state_e    state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [4:0]    byte_idx_q, byte_idx_d;
    logic [127:0]  cipher_q, cipher_d;
    logic [127:0]  aes_cipher;
    logic          tx_start;
    logic [7:0]    tx_data;
    logic          tx_busy;

    aes_top u_aes (
        .i_clock  (clk),
        .i_plain  (PLAIN),
        .i_key    (KEY),
        .o_cipher (aes_cipher)
    );

    uart_tx_8n1 #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
        .clk       (clk),
        .rst       (rst),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_busy   (tx_busy),
        .tx_serial (uart_tx)
    );

    // Sequencer: settle, snapshot the cipher once, then feed bytes 0..15 as the UART frees up.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        byte_idx_d = byte_idx_q;
        cipher_d   = cipher_q;
        tx_start   = 1'b0;
        tx_data    = cipher_byte(cipher_q, byte_idx_q[3:0]);
        case (state_q)
            WAIT_AES: begin
                if (wait_cnt_q == WAIT_W'(AES_WAIT - 1)) begin
                    cipher_d = aes_cipher;
                    state_d  = SEND;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            SEND: begin
                if (!tx_busy) begin
                    if (byte_idx_q == 5'(NUM_BYTES)) begin
                        state_d = DONE;
                    end else begin
                        tx_start   = 1'b1;
                        byte_idx_d = byte_idx_q + 1'b1;
                    end
                end
            end
            DONE: state_d = DONE;
            default: state_d = WAIT_AES;
        endcase
    end

    // Sequencer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= WAIT_AES;
            wait_cnt_q <= '0;
            byte_idx_q <= '0;
            cipher_q   <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            byte_idx_q <= byte_idx_d;
            cipher_q   <= cipher_d;
        end
    end

endmodule

// File: tb/tb_aes_uart_fpga_top.sv
// tb/tb_aes_uart_fpga_top.sv - directed self-checking bench for aes_uart_fpga_top
`timescale 1ns/1ps
module tb_aes_uart_fpga_top;

    localparam int           CPB       = 87;
    localparam int           AES_WAIT  = 32;
    localparam logic [127:0] ALT_PLAIN = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] ALT_KEY   = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    logic clk     = 1'b0;
    logic rst     = 1'b1;
    logic rst_alt = 1'b1;
    logic uart_tx;
    logic uart_tx_alt;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [127:0] exp_def = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    logic [127:0] exp_alt = 128'h3925841d02dc09fbdc118597196a0b32;

    always #50 clk = ~clk;

    aes_uart_fpga_top #(.CLKS_PER_BIT(CPB), .AES_WAIT(AES_WAIT)) dut (
        .clk     (clk),
        .rst     (rst),
        .uart_tx (uart_tx)
    );

    aes_uart_fpga_top #(.CLKS_PER_BIT(CPB), .AES_WAIT(AES_WAIT),
                        .PLAIN(ALT_PLAIN), .KEY(ALT_KEY)) dut_alt (
        .clk     (clk),
        .rst     (rst_alt),
        .uart_tx (uart_tx_alt)
    );

    function automatic logic line(input bit alt);
        return alt ? uart_tx_alt : uart_tx;
    endfunction

    task automatic wait_fall(input bit alt, input int budget, output int waited, output bit found);
        found  = 1'b0;
        waited = 0;
        while (waited < budget) begin
            @(negedge clk);
            waited++;
            if (line(alt) === 1'b0) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic recv_byte(input bit alt, output logic [7:0] data, output bit start_ok,
                             output bit stop_ok, output bit found, output int waited);
        data     = '0;
        start_ok = 1'b0;
        stop_ok  = 1'b0;
        wait_fall(alt, 2000, waited, found);
        if (!found) return;
        repeat (CPB / 2) @(negedge clk);
        start_ok = (line(alt) === 1'b0);
        for (int b = 0; b < 8; b++) begin
            repeat (CPB) @(negedge clk);
            data[b] = line(alt);
        end
        repeat (CPB) @(negedge clk);
        stop_ok = (line(alt) === 1'b1);
    endtask

    task automatic test_reset();
        int lows;
        int lows_alt;
        lows     = 0;
        lows_alt = 0;
        rst      = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) lows++;
            if (uart_tx_alt !== 1'b1) lows_alt++;
        end
        tests_run++;
        if (lows != 0) begin
            tests_failed++;
            $display("FAIL reset_idle: %0d non-high samples, required 0", lows);
        end
        tests_run++;
        if (lows_alt != 0) begin
            tests_failed++;
            $display("FAIL reset_idle_alt: %0d non-high samples, required 0", lows_alt);
        end
        rst  = 1'b0;
        lows = 0;
        repeat (AES_WAIT) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) lows++;
        end
        tests_run++;
        if (lows != 0) begin
            tests_failed++;
            $display("FAIL no_early_start: %0d low samples in first %0d cycles, required 0", lows, AES_WAIT);
        end
    endtask

    task automatic test_bit_timing();
        int   waited;
        bit   found;
        int   width;
        bit   in_start;
        int   errs;
        int   bn;
        logic expv;
        logic [7:0] b0;
        b0 = exp_def[127:120];
        wait_fall(1'b0, 20, waited, found);
        tests_run++;
        if (!found) begin
            tests_failed++;
            $display("FAIL first_start_found: no start bit within 20 cycles of AES_WAIT, required one");
        end
        width    = 1;
        in_start = 1'b1;
        errs     = 0;
        for (int k = 1; k < 10 * CPB; k++) begin
            @(negedge clk);
            bn   = k / CPB;
            expv = (bn == 0) ? 1'b0 : (bn == 9) ? 1'b1 : b0[bn-1];
            if (uart_tx !== expv) errs++;
            if (in_start && uart_tx === 1'b0) width++;
            else in_start = 1'b0;
        end
        tests_run++;
        if (width != CPB) begin
            tests_failed++;
            $display("FAIL start_width: got %0d cycles, required %0d", width, CPB);
        end
        tests_run++;
        if (errs != 0) begin
            tests_failed++;
            $display("FAIL frame_waveform: %0d cycles off the 870-cycle pattern, required 0", errs);
        end
        @(negedge clk);
        tests_run++;
        if (uart_tx !== 1'b1) begin
            tests_failed++;
            $display("FAIL frame_length: line %b at cycle 870, required 1", uart_tx);
        end
    endtask

    task automatic test_default_vectors();
        logic [7:0] d;
        bit start_ok, stop_ok, found;
        int waited;
        for (int i = 1; i < 16; i++) begin
            recv_byte(1'b0, d, start_ok, stop_ok, found, waited);
            tests_run++;
            if (!found || d !== exp_def[127-8*i -: 8] || !start_ok || !stop_ok) begin
                tests_failed++;
                $display("FAIL default_byte%0d: got %h start_ok %0d stop_ok %0d found %0d, required %h",
                         i, d, start_ok, stop_ok, found, exp_def[127-8*i -: 8]);
            end
            if (i > 1) begin
                tests_run++;
                if (waited < 44 || waited > 46) begin
                    tests_failed++;
                    $display("FAIL byte_gap%0d: start found %0d cycles after stop sample, required 44..46", i, waited);
                end
            end
        end
    endtask

    task automatic test_idle();
        int lows;
        lows = 0;
        repeat (20000) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) lows++;
        end
        tests_run++;
        if (lows != 0) begin
            tests_failed++;
            $display("FAIL idle_after_done: %0d non-high samples in 2 ms, required 0", lows);
        end
    endtask

    task automatic test_reset_mid_transfer();
        logic [7:0] d;
        bit start_ok, stop_ok, found;
        int waited;
        int errs;
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        rst  = 1'b0;
        errs = 0;
        for (int i = 0; i < 5; i++) begin
            recv_byte(1'b0, d, start_ok, stop_ok, found, waited);
            if (!found || d !== exp_def[127-8*i -: 8]) errs++;
        end
        tests_run++;
        if (errs != 0) begin
            tests_failed++;
            $display("FAIL restart_prefix: %0d of bytes 0..4 wrong, required 0", errs);
        end
        wait_fall(1'b0, 2000, waited, found);
        repeat (3 * CPB + 43) @(negedge clk);
        tests_run++;
        if (uart_tx !== 1'b0) begin
            tests_failed++;
            $display("FAIL byte5_bit2: line %b, required 0", uart_tx);
        end
        #10;
        rst = 1'b1;
        #1;
        tests_run++;
        if (uart_tx !== 1'b1) begin
            tests_failed++;
            $display("FAIL async_reset: line %b right after rst rose, required 1", uart_tx);
        end
        repeat (5) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            recv_byte(1'b0, d, start_ok, stop_ok, found, waited);
            tests_run++;
            if (!found || d !== exp_def[127-8*i -: 8] || !start_ok || !stop_ok) begin
                tests_failed++;
                $display("FAIL restart_byte%0d: got %h found %0d, required %h",
                         i, d, found, exp_def[127-8*i -: 8]);
            end
        end
    endtask

    task automatic test_alt_vectors();
        logic [7:0] d;
        bit start_ok, stop_ok, found;
        int waited;
        @(negedge clk);
        rst_alt = 1'b0;
        for (int i = 0; i < 16; i++) begin
            recv_byte(1'b1, d, start_ok, stop_ok, found, waited);
            tests_run++;
            if (!found || d !== exp_alt[127-8*i -: 8] || !start_ok || !stop_ok) begin
                tests_failed++;
                $display("FAIL alt_byte%0d: got %h start_ok %0d stop_ok %0d found %0d, required %h",
                         i, d, start_ok, stop_ok, found, exp_alt[127-8*i -: 8]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_bit_timing();
        test_default_vectors();
        test_idle();
        test_reset_mid_transfer();
        test_alt_vectors();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/aes_uart_fpga_top.md
Name: aes_uart_fpga_top

Overview:
FPGA top level that encrypts one fixed 128-bit plaintext with a fixed AES-128 key and sends the 16-byte ciphertext out of a UART TX pin.
- Uses the existing AES core aes_top (ports i_clock, i_plain, i_key, o_cipher).
- Uses one local UART transmitter.
- After reset it waits for the core to settle, then sends the 16 bytes once.
- uart_tx then stays idle-high until the next reset.

Parameters:
- CLKS_PER_BIT, 87: clk cycles per UART bit (10 MHz / 115200 baud).
- AES_WAIT, 32: clk cycles after reset release before o_cipher is sampled. Must be at least the aes_top latency.
- PLAIN, 128'h00112233445566778899aabbccddeeff: plaintext driven to i_plain.
- KEY, 128'h000102030405060708090a0b0c0d0e0f: key driven to i_key.

Ports:
- clk  input  1  system clock (10 MHz nominal)
- rst  input  1  asynchronous, active-high reset
- uart_tx  output  1  UART serial data, 8N1, idle high

Behaviour:
- Single clock domain. All flops reset asynchronously on rst=1; the reset is released synchronously.
- Reset values:
  - uart_tx = 1; state = WAIT_AES; wait counter = 0; byte index = 0.
  - Cipher register = 0; UART baud counter = 0; UART bit index = 0.
- aes_top:
  - i_clock = clk, i_plain = PLAIN, i_key = KEY, held constant.
  - o_cipher[127:0] is big-endian; byte 0 = bits [127:120].
- State WAIT_AES:
  - Count clk cycles up to AES_WAIT-1.
  - On the terminal count, latch o_cipher into the cipher register and go to SEND.
- State SEND:
  - When the UART is idle, issue a one-cycle tx_start with tx_data = cipher byte[byte index].
  - Bytes go in order 0..15, most significant byte first.
  - Increment the byte index on each start.
  - Once byte 15 is accepted and the UART returns to idle, go to DONE.
- State DONE: no further starts; uart_tx = 1 permanently; stays here until rst.
- UART frame, each bit exactly CLKS_PER_BIT cycles:
  - 1 start bit (0), then 8 data bits LSB first, then 1 stop bit (1).
  - Total frame = 10*CLKS_PER_BIT cycles.
- Byte spacing:
  - The next tx_start is issued on the cycle after tx_busy falls.
  - The gap between consecutive stop-bit ends and start-bit begins is at most 2 clk cycles.
  - Minimum idle between frames is 0 extra bit times.
- tx_start while busy is ignored by the UART. The sequencer never issues one.
- Reset mid-frame: uart_tx returns to 1 immediately (asynchronously). The whole sequence restarts from WAIT_AES after release.
- o_cipher is sampled only once, at the WAIT_AES terminal count. Later o_cipher changes have no effect.
- Expected ciphertext with the default parameters (FIPS-197 C.1): 69c4e0d86a7b0430d8cdb78070b4c55a.
- Full transmission lasts 160*CLKS_PER_BIT cycles, plus at most 30 cycles of gaps.

Decomposition:
- Shared package aes_uart_pkg holds:
  - State enum {WAIT_AES, SEND, DONE}.
  - Default PLAIN and KEY constants.
  - NUM_BYTES = 16.
  - UART frame constants: START = 0, STOP = 1, DATA_BITS = 8.
- One sub-module, uart_tx_8n1.
  - Parameter: CLKS_PER_BIT.
  - Ports: clk, rst, tx_start, tx_data[7:0], tx_busy, tx_serial.
  - Internal states: IDLE, START_BIT, DATA_BITS, STOP_BIT.
  - tx_busy is high from the cycle after tx_start through the last stop-bit cycle.
- aes_top is an existing codebase block and is instantiated unchanged.
- Top-level sequencer plus UART: roughly 150-200 lines.

Test Plan:
- Reset check: hold rst=1 for 5 cycles -> uart_tx=1 throughout; no falling edge before AES_WAIT cycles after release.
- Default vectors, 10 MHz clock, UART decoded at 87 cycles/bit -> exactly 16 bytes are received: 69 c4 e0 d8 6a 7b 04 30 d8 cd b7 80 70 b4 c5 5a. Each frame has start=0 and stop=1.
- Bit timing: measure the first frame -> start-bit low width = 87 cycles; every bit boundary is at a multiple of 87 cycles from the start edge; frame length = 870 cycles.
- Alternate parameters: PLAIN=3243f6a8885a308d313198a2e0370734, KEY=2b7e151628aed2a6abf7158809cf4f3c -> bytes 39 25 84 1d 02 dc 09 fb dc 11 85 97 19 6a 0b 32.
- Completion/idle: run 2 ms after the last stop bit -> uart_tx stays 1 with no further frames.
- Reset mid-transfer: assert rst during byte 5's data bits -> uart_tx=1 immediately. After release, the full 16-byte sequence repeats from byte 0x69.
